shift_sequencer: RTL



---
 rtl/shift_seq_pkg.sv | 31 +++
 rtl/shift_step.sv | 54 +++++
 rtl/shift_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shifter-operand sequencer: op codes, FSM states,
// datapath width and the immediate-rotate helper.
package shift_seq_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    OP_LSL   = 3'd0,
    OP_LSR   = 3'd1,
    OP_ASR   = 3'd2,
    OP_ROR   = 3'd3,
    OP_RRX   = 3'd4,
    OP_IMM   = 3'd5,
    OP_PASS6 = 3'd6,
    OP_PASS7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Full 32-bit rotate right, used when an immediate is resolved in one cycle.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] dbl;
    dbl = {v, v} >> r;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-chunk shifter: moves the working value by s (0..4) bits
// for the selected op and reports the last bit shifted out.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       s,
  input  logic             carry_in,
  output logic [WIDTH-1:0] value_out,
  output logic             carry_out
);

  logic [WIDTH:0]        lsl_ext;
  logic [WIDTH:0]        lsr_ext;
  logic signed [WIDTH:0] asr_ext;
  logic [WIDTH-1:0]      ror_val;
  logic [5:0]            ror_left;

  // One guard bit on the shifted-out side captures the carry for free.
  always_comb begin
    lsl_ext   = {1'b0, value} << s;
    lsr_ext   = {value, 1'b0} >> s;
    asr_ext   = $signed({value, 1'b0}) >>> s;
    ror_left  = 6'(WIDTH) - {3'b000, s};
    ror_val   = (value >> s) | (value << ror_left);
    value_out = value;
    carry_out = carry_in;
    if (s != 3'd0) begin
      case (op)
        OP_LSL: begin
          value_out = lsl_ext[WIDTH-1:0];
          carry_out = lsl_ext[WIDTH];
        end
        OP_LSR: begin
          value_out = lsr_ext[WIDTH:1];
          carry_out = lsr_ext[0];
        end
        OP_ASR: begin
          value_out = asr_ext[WIDTH:1];
          carry_out = asr_ext[0];
        end
        OP_ROR, OP_IMM: begin
          value_out = ror_val;
          carry_out = ror_val[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter-operand controller: runs LSL/LSR/ASR/ROR/RRX/IMM through
// a STEP-bit shift stage. Define SHIFT_SEQ_IMM_FASTPATH_EN to resolve IMM at accept.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [7:0]       amount,
  input  logic [11:0]      imm12,
  input  logic             carry_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);

  localparam logic [5:0] STEP_N = 6'(STEP);
  localparam logic [2:0] STEP_S = 3'(STEP);

  state_e           state, state_nxt;
  logic [2:0]       op_q;
  logic [5:0]       rem_q;
  logic             clr_q;
  logic [WIDTH-1:0] work_q;
  logic             carry_q;

  logic [WIDTH-1:0] acc_work;
  logic             acc_carry;
  logic             acc_clr;
  logic [5:0]       acc_n;

  logic [2:0]       step_s;
  logic             last_step;
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  function automatic logic [5:0] sat_count(input logic [7:0] a);
    return (a > 8'd32) ? 6'd32 : a[5:0];
  endfunction

  // Accept decode: effective count and preloaded working value/carry.
  always_comb begin
    acc_work  = operand;
    acc_carry = carry_in;
    acc_clr   = 1'b0;
    acc_n     = 6'd0;
    case (op)
      OP_LSL, OP_LSR: begin
        acc_n   = sat_count(amount);
        acc_clr = (amount > 8'd32);
      end
      OP_ASR: acc_n = sat_count(amount);
      OP_ROR: begin
        if (amount != 8'd0) begin
          if (amount[4:0] == 5'd0) acc_carry = operand[WIDTH-1];
          else                     acc_n     = {1'b0, amount[4:0]};
        end
      end
      OP_RRX: begin
        acc_work  = {carry_in, operand[WIDTH-1:1]};
        acc_carry = operand[0];
      end
      OP_IMM: begin
`ifdef SHIFT_SEQ_IMM_FASTPATH_EN
        acc_work  = ror32({24'd0, imm12[7:0]}, {imm12[11:8], 1'b0});
        acc_carry = (imm12[11:8] == 4'd0) ? carry_in : acc_work[WIDTH-1];
`else
        acc_work  = {{(WIDTH-8){1'b0}}, imm12[7:0]};
        acc_n     = {1'b0, imm12[11:8], 1'b0};
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    step_s    = (rem_q < STEP_N) ? rem_q[2:0] : STEP_S;
    last_step = (rem_q <= STEP_N);
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .value     (work_q),
    .s         (step_s),
    .carry_in  (carry_q),
    .value_out (step_val),
    .carry_out (step_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = (acc_n != 6'd0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (last_step) state_nxt = ST_DONE;
      ST_DONE:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_DONE);
    busy       = (state != ST_IDLE);
    result     = work_q;
    carry_out  = carry_q;
  end

  // Datapath: load on accept, one chunk per SHIFT cycle, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 3'd0;
      rem_q   <= 6'd0;
      clr_q   <= 1'b0;
      work_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= op;
            rem_q   <= acc_n;
            clr_q   <= acc_clr;
            work_q  <= acc_work;
            carry_q <= acc_carry;
          end
        end
        ST_SHIFT: begin
          work_q  <= step_val;
          rem_q   <= rem_q - {3'b000, step_s};
          // Over-range logical shifts finish as a 32-bit shift with carry forced low.
          carry_q <= (last_step && clr_q) ? 1'b0 : step_carry;
        end
        default: ;
      endcase
    end
  end

endmodule
